// File: rtl/hazard_pkg.sv
// Shared types for the RV32 pipeline hazard controller: forwarding selects and
// data-memory wait FSM states.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        ERR  = 2'b10
    } mem_state_t;

    localparam int DEF_MEM_TIMEOUT = 15;

endpackage

// File: rtl/mem_wait_fsm.sv
// Data-memory wait sequencer: tracks req/ack handshakes, raises the stall request,
// and times out a wait that exceeds MEM_TIMEOUT cycles.
module mem_wait_fsm
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic i_mem_req,
    input  logic i_mem_ack,
    output logic o_mem_stall,
    output logic o_busy,
    output logic o_err
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    mem_state_t      r_state;
    mem_state_t      w_next_state;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_next_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        o_mem_stall  = 1'b0;
        o_busy       = 1'b0;
        o_err        = 1'b0;
        case (r_state)
            IDLE: begin
                // Ack in the request cycle costs no stall at all.
                if (i_mem_req && !i_mem_ack) begin
                    o_mem_stall  = 1'b1;
                    w_next_state = WAIT;
                    w_next_cnt   = CW'(1);
                end
            end
            WAIT: begin
                o_busy = 1'b1;
                if (i_mem_ack) begin
                    w_next_state = IDLE;
                    w_next_cnt   = '0;
                end else begin
                    o_mem_stall = 1'b1;
                    if (r_cnt == CW'(MEM_TIMEOUT)) begin
                        w_next_state = ERR;
                        w_next_cnt   = '0;
                    end else begin
                        w_next_cnt = r_cnt + CW'(1);
                    end
                end
            end
            ERR: begin
                o_err        = 1'b1;
                w_next_state = IDLE;
                w_next_cnt   = '0;
            end
            default: begin
                w_next_state = IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32 pipeline: EX forwarding, load-use
// stalls, branch flushes and memory-wait stalls. Macro PERF_CNT_EN adds perf counters.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
`ifdef PERF_CNT_EN
    ,
    parameter int CNT_W       = 32
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              LoadE,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              PCSrcE,
    input  logic              MemReqM,
    input  logic              MemAckM,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushW,
    output logic              MemBusy,
    output logic              MemErr
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  StallCnt,
    output logic [CNT_W-1:0]  FlushCnt,
    output logic [CNT_W-1:0]  MemErrCnt
`endif
);

    logic     w_mem_stall;
    logic     w_mem_busy;
    logic     w_mem_err;
    logic     w_lw_stall;
    fwd_sel_t w_fwd_a;
    fwd_sel_t w_fwd_b;

    function automatic fwd_sel_t fwd_select(
        input logic [REG_AW-1:0] rs,
        input logic              wr_m,
        input logic [REG_AW-1:0] rd_m,
        input logic              wr_w,
        input logic [REG_AW-1:0] rd_w
    );
        if (wr_m && (rd_m == rs) && (rd_m != '0))
            return FWD_MEM;
        else if (wr_w && (rd_w == rs) && (rd_w != '0))
            return FWD_WB;
        return FWD_RF;
    endfunction

    mem_wait_fsm #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_mem_wait_fsm (
        .clk         (clk),
        .reset       (reset),
        .i_mem_req   (MemReqM),
        .i_mem_ack   (MemAckM),
        .o_mem_stall (w_mem_stall),
        .o_busy      (w_mem_busy),
        .o_err       (w_mem_err)
    );

    assign w_fwd_a    = fwd_select(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
    assign w_fwd_b    = fwd_select(Rs2E, RegWriteM, RdM, RegWriteW, RdW);
    assign w_lw_stall = LoadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

    always_comb begin
        ForwardAE = w_fwd_a;
        ForwardBE = w_fwd_b;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        MemBusy   = w_mem_busy;
        MemErr    = w_mem_err;
        // A taken branch waiting behind a memory stall stays in EX and fires on release.
        if (w_mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else if (PCSrcE) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
        end else if (w_lw_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
        end
        if (w_mem_err)
            FlushW = 1'b1;
        if (reset) begin
            ForwardAE = FWD_RF;
            ForwardBE = FWD_RF;
            StallF    = 1'b0;
            StallD    = 1'b0;
            StallE    = 1'b0;
            StallM    = 1'b0;
            FlushD    = 1'b1;
            FlushE    = 1'b1;
            FlushW    = 1'b1;
            MemBusy   = 1'b0;
            MemErr    = 1'b0;
        end
    end

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic [CNT_W-1:0] r_err_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            if (StallF || StallD || StallE || StallM)
                r_stall_cnt <= sat_inc(r_stall_cnt);
            if (FlushD || FlushE)
                r_flush_cnt <= sat_inc(r_flush_cnt);
            if (MemErr)
                r_err_cnt <= sat_inc(r_err_cnt);
        end
    end

    assign StallCnt  = r_stall_cnt;
    assign FlushCnt  = r_flush_cnt;
    assign MemErrCnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (default build).
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       LoadE, RegWriteM, RegWriteW, PCSrcE, MemReqM, MemAckM;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemBusy, MemErr;
`ifdef PERF_CNT_EN
    logic [31:0] StallCnt, FlushCnt, MemErrCnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .Rs1D      (Rs1D),
        .Rs2D      (Rs2D),
        .Rs1E      (Rs1E),
        .Rs2E      (Rs2E),
        .RdE       (RdE),
        .RdM       (RdM),
        .RdW       (RdW),
        .LoadE     (LoadE),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .PCSrcE    (PCSrcE),
        .MemReqM   (MemReqM),
        .MemAckM   (MemAckM),
        .ForwardAE (ForwardAE),
        .ForwardBE (ForwardBE),
        .StallF    (StallF),
        .StallD    (StallD),
        .StallE    (StallE),
        .StallM    (StallM),
        .FlushD    (FlushD),
        .FlushE    (FlushE),
        .FlushW    (FlushW),
        .MemBusy   (MemBusy),
        .MemErr    (MemErr)
`ifdef PERF_CNT_EN
        ,
        .StallCnt  (StallCnt),
        .FlushCnt  (FlushCnt),
        .MemErrCnt (MemErrCnt)
`endif
    );

    // Packs {StallF,StallD,StallE,StallM,FlushD,FlushE,FlushW} for compact comparisons.
    function automatic logic [6:0] ctl();
        return {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
    endfunction

    task automatic drive_idle();
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
        RdE = '0; RdM = '0; RdW = '0;
        LoadE = 0; RegWriteM = 0; RegWriteW = 0;
        PCSrcE = 0; MemReqM = 0; MemAckM = 0;
    endtask

    task automatic test_reset();
        drive_idle();
        RegWriteM = 1; RdM = 5; Rs1E = 5; Rs2E = 5;
        MemReqM = 1; PCSrcE = 1;
        @(negedge clk);
        checks++;
        if (ctl() !== 7'b0000111) begin
            errors++; $display("FAIL reset_ctl got %b want 0000111", ctl());
        end
        checks++;
        if (ForwardAE !== 2'b00 || ForwardBE !== 2'b00) begin
            errors++; $display("FAIL reset_fwd got %b/%b want 00/00", ForwardAE, ForwardBE);
        end
        checks++;
        if (MemBusy !== 1'b0 || MemErr !== 1'b0) begin
            errors++; $display("FAIL reset_mem got busy=%b err=%b want 0/0", MemBusy, MemErr);
        end
        drive_idle();
        reset = 0;
        @(negedge clk);
        checks++;
        if (ctl() !== 7'b0000000 || MemBusy !== 1'b0) begin
            errors++; $display("FAIL post_reset got ctl=%b busy=%b want 0000000/0", ctl(), MemBusy);
        end
    endtask

    task automatic test_forwarding();
        @(posedge clk); #1;
        drive_idle();
        RdM = 5; RegWriteM = 1; RdW = 5; RegWriteW = 1; Rs1E = 5; Rs2E = 3;
        @(negedge clk);
        checks++;
        if (ForwardAE !== 2'b10) begin
            errors++; $display("FAIL fwd_mem_prio got %b want 10", ForwardAE);
        end
        checks++;
        if (ForwardBE !== 2'b00) begin
            errors++; $display("FAIL fwd_b_nomatch got %b want 00", ForwardBE);
        end
        RdM = 0; Rs2E = 0;
        #1;
        checks++;
        if (ForwardAE !== 2'b01) begin
            errors++; $display("FAIL fwd_wb got %b want 01", ForwardAE);
        end
        checks++;
        if (ForwardBE !== 2'b00) begin
            errors++; $display("FAIL fwd_x0_mem got %b want 00", ForwardBE);
        end
        RegWriteW = 0;
        #1;
        checks++;
        if (ForwardAE !== 2'b00) begin
            errors++; $display("FAIL fwd_no_write got %b want 00", ForwardAE);
        end
        RdM = 9; RegWriteM = 0; RdW = 9; RegWriteW = 1; Rs2E = 9; RdE = 0; Rs1E = 0;
        #1;
        checks++;
        if (ForwardBE !== 2'b01 || ForwardAE !== 2'b00) begin
            errors++; $display("FAIL fwd_b_wb got %b/%b want 00/01", ForwardAE, ForwardBE);
        end
        RdW = 0; Rs2E = 0;
        #1;
        checks++;
        if (ForwardBE !== 2'b00) begin
            errors++; $display("FAIL fwd_x0_wb got %b want 00", ForwardBE);
        end
    endtask

    task automatic test_load_use();
        @(posedge clk); #1;
        drive_idle();
        LoadE = 1; RdE = 7; Rs2D = 7; Rs1D = 2;
        @(negedge clk);
        checks++;
        if (ctl() !== 7'b1100010) begin
            errors++; $display("FAIL lw_stall got %b want 1100010", ctl());
        end
        @(posedge clk); #1;
        drive_idle();
        RdM = 7; RegWriteM = 1; Rs2E = 7;
        @(negedge clk);
        checks++;
        if (ForwardBE !== 2'b10 || ctl() !== 7'b0000000) begin
            errors++; $display("FAIL lw_fwd got fwdB=%b ctl=%b want 10/0000000", ForwardBE, ctl());
        end
        @(posedge clk); #1;
        drive_idle();
        LoadE = 1; RdE = 0; Rs1D = 0;
        @(negedge clk);
        checks++;
        if (ctl() !== 7'b0000000) begin
            errors++; $display("FAIL lw_x0 got %b want 0000000", ctl());
        end
    endtask

    task automatic test_branch_over_load();
        @(posedge clk); #1;
        drive_idle();
        LoadE = 1; RdE = 7; Rs1D = 7; PCSrcE = 1;
        @(negedge clk);
        checks++;
        if (ctl() !== 7'b0000110) begin
            errors++; $display("FAIL branch_lw got %b want 0000110", ctl());
        end
    endtask

    task automatic test_mem_wait();
        @(posedge clk); #1;
        drive_idle();
        MemReqM = 1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (ctl() !== 7'b1111001 || MemBusy !== (c != 0)) begin
                errors++; $display("FAIL wait_cyc%0d got ctl=%b busy=%b want 1111001/%0d", c, ctl(), MemBusy, c != 0);
            end
            @(posedge clk); #1;
        end
        MemAckM = 1;
        @(negedge clk);
        checks++;
        if (ctl() !== 7'b0000000) begin
            errors++; $display("FAIL ack_cycle got %b want 0000000", ctl());
        end
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        checks++;
        if (MemBusy !== 1'b0 || ctl() !== 7'b0000000) begin
            errors++; $display("FAIL after_ack got busy=%b ctl=%b want 0/0000000", MemBusy, ctl());
        end
        @(posedge clk); #1;
        MemReqM = 1; MemAckM = 1;
        @(negedge clk);
        checks++;
        if (ctl() !== 7'b0000000) begin
            errors++; $display("FAIL zero_lat got %b want 0000000", ctl());
        end
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        checks++;
        if (MemBusy !== 1'b0) begin
            errors++; $display("FAIL zero_lat_busy got %b want 0", MemBusy);
        end
    endtask

    task automatic test_mem_timeout();
        int err_cyc = -1;
        int n_stall = 0;
        int n_fd    = 0;
        int n_busy  = 0;
        @(posedge clk); #1;
        drive_idle();
        MemReqM = 1; PCSrcE = 1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (MemErr) begin
                err_cyc = i;
                break;
            end
            if (StallF) n_stall++;
            if (FlushD) n_fd++;
            if (MemBusy) n_busy++;
            @(posedge clk); #1;
        end
        checks++;
        if (err_cyc != 16) begin
            errors++; $display("FAIL timeout_cycle got %0d want 16", err_cyc);
        end
        checks++;
        if (n_stall != 16 || n_busy != 15 || n_fd != 0) begin
            errors++; $display("FAIL timeout_wait got stall=%0d busy=%0d flushD=%0d want 16/15/0", n_stall, n_busy, n_fd);
        end
        checks++;
        if (ctl() !== 7'b0000111) begin
            errors++; $display("FAIL err_cycle got %b want 0000111", ctl());
        end
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        checks++;
        if (MemErr !== 1'b0 || MemBusy !== 1'b0 || ctl() !== 7'b0000000) begin
            errors++; $display("FAIL after_err got err=%b busy=%b ctl=%b want 0/0/0000000", MemErr, MemBusy, ctl());
        end
    endtask

    task automatic test_reset_mid_wait();
        @(posedge clk); #1;
        drive_idle();
        MemReqM = 1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (MemBusy !== 1'b1) begin
            errors++; $display("FAIL pre_reset_busy got %b want 1", MemBusy);
        end
        #1;
        reset = 1;
        #1;
        checks++;
        if (MemBusy !== 1'b0 || ctl() !== 7'b0000111) begin
            errors++; $display("FAIL mid_reset got busy=%b ctl=%b want 0/0000111", MemBusy, ctl());
        end
        @(negedge clk);
        checks++;
        if (MemBusy !== 1'b0 || ctl() !== 7'b0000111) begin
            errors++; $display("FAIL held_reset got busy=%b ctl=%b want 0/0000111", MemBusy, ctl());
        end
        drive_idle();
        reset = 0;
        @(negedge clk);
        checks++;
        if (MemBusy !== 1'b0 || ctl() !== 7'b0000000) begin
            errors++; $display("FAIL reset_release got busy=%b ctl=%b want 0/0000000", MemBusy, ctl());
        end
    endtask

    initial begin
        reset = 1;
        drive_idle();
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch_over_load();
        test_mem_wait();
        test_mem_timeout();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
